// File: rtl/cnn_mac_pkg.sv
// Shared widths, beat sideband type and output clamp helper for the pipelined CNN MAC.
package cnn_mac_pkg;

  function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  function automatic int unsigned acc_w(input int unsigned a_w, input int unsigned b_w,
                                        input int unsigned guard);
    return a_w + b_w + guard;
  endfunction

  typedef struct packed {
    logic first;
    logic last;
    logic valid;
  } beat_sb_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } clip_t;

  // Clamp a signed value into the w-bit two's-complement range.
  function automatic clip_t sat_clip(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    clip_t              r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r.sat = 1'b1;
    if (v > hi) begin
      r.val = hi;
    end else if (v < lo) begin
      r.val = lo;
    end else begin
      r.val = v;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A_W x B_W multiplier followed by NUM_STAGE enable-gated registers with sideband.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned A_W       = 16,
  parameter int unsigned B_W       = 11,
  parameter int unsigned NUM_STAGE = 2,
  localparam int unsigned PROD_W   = prod_w(A_W, B_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic signed [A_W-1:0]    a_i,
  input  logic signed [B_W-1:0]    b_i,
  input  beat_sb_t                 sb_i,
  output logic signed [PROD_W-1:0] prod_o,
  output beat_sb_t                 sb_o
);

  logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
  beat_sb_t                 sb_q   [NUM_STAGE];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_STAGE; i++) sb_q[i] <= '0;
    end else if (en_i) begin
      sb_q[0] <= sb_i;
      for (int i = 1; i < NUM_STAGE; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Product data left unreset so the registers map onto DSP M/P stages.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      prod_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
      for (int i = 1; i < NUM_STAGE; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign prod_o = prod_q[NUM_STAGE-1];
  assign sb_o   = sb_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed MAC: accumulates first..last groups, emits scaled result on valid/ready.
// Define CNN_MAC_SAT_EN to clamp the output (out_sat flags clipping); otherwise it wraps.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned A_W        = 16,
  parameter int unsigned B_W        = 11,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned ACC_GUARD  = 8,
  parameter int unsigned FRAC_SHIFT = 10,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned PROD_W = prod_w(A_W, B_W);
  localparam int unsigned ACC_W  = acc_w(A_W, B_W, ACC_GUARD);

  logic                     en;
  beat_sb_t                 sb_in, sb_p;
  logic signed [PROD_W-1:0] prod_p;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum, scaled;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d, res_data;
  logic                     out_valid_q, out_valid_d, out_sat_q, out_sat_d, res_sat;
  logic                     load;
  logic                     unused_bits;

  // A pending result that downstream refuses stalls the whole pipe.
  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;

  always_comb begin
    sb_in       = '0;
    sb_in.first = in_first;
    sb_in.last  = in_last;
    sb_in.valid = in_valid;
  end

  cnn_mac_mul_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk_i (ap_clk),
    .rst_ni(ap_rst_n),
    .en_i  (en),
    .a_i   (in_a),
    .b_i   (in_b),
    .sb_i  (sb_in),
    .prod_o(prod_p),
    .sb_o  (sb_p)
  );

  assign acc_sum = sb_p.first ? ACC_W'(prod_p) : acc_q + ACC_W'(prod_p);
  assign scaled  = acc_sum >>> FRAC_SHIFT;

`ifdef CNN_MAC_SAT_EN
  clip_t clip;
  assign clip        = sat_clip(64'(scaled), OUT_W);
  assign res_data    = clip.val[OUT_W-1:0];
  assign res_sat     = clip.sat;
  assign unused_bits = ^clip.val[63:OUT_W];
`else
  assign res_data    = scaled[OUT_W-1:0];
  assign res_sat     = 1'b0;
  assign unused_bits = ^scaled[ACC_W-1:OUT_W];
`endif

  assign load = en && sb_p.valid && sb_p.last;

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (en && sb_p.valid) acc_d = acc_sum;
    // With en high the current result is either absent or being taken this cycle.
    if (en) out_valid_d = load;
    if (load) begin
      out_data_d = res_data;
      out_sat_d  = res_sat;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed self-checking bench for cnn_mac_pipe (default parameters).
module tb_cnn_mac_pipe;

  logic               ap_clk    = 1'b0;
  logic               ap_rst_n  = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_first  = 1'b0;
  logic               in_last   = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [15:0] in_a      = '0;
  logic signed [10:0] in_b      = '0;
  logic               in_ready, out_valid, out_sat;
  logic signed [15:0] out_data;

  int n_checks  = 0;
  int n_pass    = 0;
  int stall_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic signed [31:0] data;
    logic               sat;
    int                 cyc;
  } res_t;
  res_t q[$];

  cnn_mac_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    res_t r;
    cyc++;
    if (ap_rst_n && out_valid && out_ready) begin
      r.data = 32'(out_data);
      r.sat  = out_sat;
      r.cyc  = cyc;
      q.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input int a, input int b, input bit f, input bit l);
    int t;
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 11'(b);
    in_first = f;
    in_last  = l;
    t = 0;
    while (!in_ready) begin
      if (t >= 200) begin
        check("send_timeout_in_ready", 32'(in_ready), 1);
        return;
      end
      t++;
      stall_cnt++;
      @(negedge ap_clk);
    end
    @(posedge ap_clk);
  endtask

  task automatic idle();
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_n(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (q.size() < n && t < budget) begin
      @(negedge ap_clk);
      t++;
    end
    if (q.size() < n) check({tag, "_timeout_count"}, q.size(), n);
  endtask

  task automatic pop_check(input string tag, input int exp_d, input bit exp_s,
                           output int cyc_o);
    res_t r;
    cyc_o = 0;
    if (q.size() == 0) begin
      check({tag, "_present"}, q.size(), 1);
      return;
    end
    r = q.pop_front();
    check({tag, "_data"}, r.data, exp_d);
    check({tag, "_sat"}, 32'(r.sat), 32'(exp_s));
    cyc_o = r.cyc;
  endtask

  initial begin
    int c, prev;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rst_in_ready", 32'(in_ready), 1);

    // 1: single beat, latency NUM_STAGE
    in_valid = 1'b1; in_a = 16'sd1024; in_b = 11'sd3; in_first = 1'b1; in_last = 1'b1;
    check("t1_in_ready", 32'(in_ready), 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    check("t1_valid_k0", 32'(out_valid), 0);
    @(negedge ap_clk);
    check("t1_valid_k1", 32'(out_valid), 0);
    @(negedge ap_clk);
    check("t1_valid_k2", 32'(out_valid), 1);
    check("t1_out_data", 32'(out_data), 3);
    check("t1_out_sat", 32'(out_sat), 0);
    wait_n("t1", 1, 10);
    pop_check("t1_res", 3, 1'b0, c);

    // 2: three-beat group, 2048 -> 2, exactly one result
    send(1024, 2, 1'b1, 1'b0);
    send(2048, -1, 1'b0, 1'b0);
    send(512, 4, 1'b0, 1'b1);
    idle();
    wait_n("t2", 1, 20);
    repeat (5) @(negedge ap_clk);
    check("t2_count", q.size(), 1);
    pop_check("t2_res", 2, 1'b0, c);

    // 3: backpressure for 5 cycles, beats held not lost
    @(negedge ap_clk);
    out_ready = 1'b0;
    send(1024, 5, 1'b1, 1'b1);
    send(1024, 6, 1'b1, 1'b1);
    send(1024, 7, 1'b1, 1'b1);
    @(negedge ap_clk);
    in_valid = 1'b1; in_a = 16'sd1024; in_b = 11'sd8; in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready_low", 32'(in_ready), 0);
      check("t3_valid_held", 32'(out_valid), 1);
      check("t3_data_stable", 32'(out_data), 5);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    idle();
    wait_n("t3", 4, 30);
    pop_check("t3_r5", 5, 1'b0, c);
    pop_check("t3_r6", 6, 1'b0, c);
    pop_check("t3_r7", 7, 1'b0, c);
    pop_check("t3_r8", 8, 1'b0, c);

    // 4: 8 beats of -32768 * -1024 = 2^28, scaled 2^18
    for (int i = 0; i < 8; i++) send(-32768, -1024, i == 0, i == 7);
    idle();
    wait_n("t4", 1, 20);
`ifdef CNN_MAC_SAT_EN
    pop_check("t4_res", 32767, 1'b1, c);
`else
    pop_check("t4_res", 0, 1'b0, c);
`endif

    // 5: reset mid-group discards in-flight beats
    send(1024, 4, 1'b1, 1'b0);
    send(1024, 4, 1'b0, 1'b1);
    @(negedge ap_clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_data", 32'(out_data), 0);
    check("t5_rst_in_ready", 32'(in_ready), 1);
    repeat (6) @(negedge ap_clk);
    check("t5_no_output", q.size(), 0);
    send(512, 2, 1'b1, 1'b1);
    idle();
    wait_n("t5", 1, 20);
    pop_check("t5_res", 1, 1'b0, c);
    // Beat without first adds onto acc (1024 + 1024 -> 2)
    send(1024, 1, 1'b0, 1'b1);
    idle();
    wait_n("t5b", 1, 20);
    pop_check("t5b_res", 2, 1'b0, c);

    // 6: 20 back-to-back single-beat groups at full rate
    stall_cnt = 0;
    for (int k = 0; k < 20; k++) send(k * 1024, 1, 1'b1, 1'b1);
    idle();
    wait_n("t6", 20, 60);
    check("t6_no_stall", stall_cnt, 0);
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      pop_check($sformatf("t6_r%0d", k), k, 1'b0, c);
      if (k > 0) check($sformatf("t6_gap%0d", k), c - prev, 1);
      prev = c;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
